// File: rtl/player_shot_controller.sv
// -----------------------------------------------------------------------------
// player_shot_controller
//
// Launches and flies the player's missile. A fire edge (fire key newly pressed,
// sampled once per frame) launches a missile centred on the player sprite; the
// missile climbs MISSILE_SPEED pixels per frame until it would pass TOP_LIMIT
// or until a collision ends the flight (reported with hitPulse).
//
// Optional feature (macro SHOT_COOLDOWN_EN): when defined, every finished
// flight is followed by a COOLDOWN of COOLDOWN_FRAMES frames during which no
// launch is accepted. When undefined, the block returns straight to IDLE.
//
// Ports:
//   clk              system clock
//   resetN           asynchronous active-low reset
//   startOfFrame     one-clock pulse per video frame
//   firePress        fire key level
//   collision        missile overlaps a target/shield (level, any cycle)
//   playerTopLeftX   current player top-left X (signed 11-bit)
//   missileTopLeftX  missile top-left X (frozen at launch)
//   missileTopLeftY  missile top-left Y
//   missileActive    high while the missile is in flight
//   shotFired        one-clock pulse on launch
//   hitPulse         one-clock pulse when a flight ends by collision
// -----------------------------------------------------------------------------
module player_shot_controller #(
    parameter int PLAYER_WIDTH    = 64,
    parameter int MISSILE_WIDTH   = 4,
    parameter int SPAWN_Y         = 290,
    parameter int MISSILE_SPEED   = 8,
    parameter int TOP_LIMIT       = 0,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               firePress,
    input  logic               collision,
    input  logic signed [10:0] playerTopLeftX,
    output logic signed [10:0] missileTopLeftX,
    output logic signed [10:0] missileTopLeftY,
    output logic               missileActive,
    output logic               shotFired,
    output logic               hitPulse
);

    localparam logic signed [10:0] X_OFFSET = 11'(PLAYER_WIDTH / 2 - MISSILE_WIDTH / 2);
    localparam logic signed [10:0] SPAWN11  = 11'(SPAWN_Y);
    localparam logic signed [11:0] SPEED12  = 12'(MISSILE_SPEED);
    localparam logic signed [11:0] TOP12    = 12'(TOP_LIMIT);

    if (COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 255) begin : g_bad_cooldown
        $error("COOLDOWN_FRAMES must be in 1..255");
    end

`ifdef SHOT_COOLDOWN_EN
    typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;
    logic [7:0] cooldownCnt;
`else
    typedef enum logic [0:0] {IDLE, FLYING} state_t;
`endif

    state_t             state;
    logic               firePrev;
    logic               fireEdge;
    logic signed [11:0] yStep;
    logic               yFits;
    logic               flightDone;

    assign fireEdge = startOfFrame && firePress && !firePrev;

    // One extra bit so the step below TOP_LIMIT cannot wrap around.
    assign yStep = {missileTopLeftY[10], missileTopLeftY} - SPEED12;
    assign yFits = (yStep >= TOP12);

    // Collision takes priority over the frame step on the same clock.
    assign flightDone = (state == FLYING) &&
                        (collision || (startOfFrame && !yFits));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= IDLE;
            firePrev        <= 1'b0;
            missileTopLeftX <= '0;
            missileTopLeftY <= '0;
            missileActive   <= 1'b0;
            shotFired       <= 1'b0;
            hitPulse        <= 1'b0;
`ifdef SHOT_COOLDOWN_EN
            cooldownCnt     <= '0;
`endif
        end else begin
            shotFired <= 1'b0;
            hitPulse  <= 1'b0;

            if (startOfFrame) begin
                firePrev <= firePress;
            end

            case (state)
                IDLE: begin
                    if (fireEdge) begin
                        state           <= FLYING;
                        missileTopLeftX <= playerTopLeftX + X_OFFSET;
                        missileTopLeftY <= SPAWN11;
                        missileActive   <= 1'b1;
                        shotFired       <= 1'b1;
                    end
                end

                FLYING: begin
                    if (flightDone) begin
                        missileActive <= 1'b0;
                        hitPulse      <= collision;
`ifdef SHOT_COOLDOWN_EN
                        state         <= COOLDOWN;
                        cooldownCnt   <= 8'(COOLDOWN_FRAMES);
`else
                        state         <= IDLE;
`endif
                    end else if (startOfFrame) begin
                        missileTopLeftY <= yStep[10:0];
                    end
                end

`ifdef SHOT_COOLDOWN_EN
                // A fire edge on the expiring frame is dropped simply because
                // the state is still COOLDOWN on that clock.
                COOLDOWN: begin
                    if (startOfFrame) begin
                        cooldownCnt <= cooldownCnt - 8'd1;
                        if (cooldownCnt == 8'd1) begin
                            state <= IDLE;
                        end
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_shot_controller.sv
// -----------------------------------------------------------------------------
// tb_player_shot_controller
//
// Directed scenarios followed by a randomized phase. Every clock the DUT
// outputs are compared against a behavioural model of the shot rules.
// Honours SHOT_COOLDOWN_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_player_shot_controller;

    localparam int PW    = 64;
    localparam int MW    = 4;
    localparam int SPAWN = 290;
    localparam int SPEED = 8;
    localparam int TOP   = 0;
    localparam int COOL  = 15;

    logic               clk = 1'b0;
    logic               resetN;
    logic               sof;
    logic               fire;
    logic               col;
    logic signed [10:0] px;
    logic signed [10:0] missileTopLeftX;
    logic signed [10:0] missileTopLeftY;
    logic               missileActive;
    logic               shotFired;
    logic               hitPulse;

    int total = 0;
    int bad   = 0;
    int nShot = 0;

    // Behavioural model state
    bit m_fly;
    int m_cd;
    bit m_fprev;
    int m_x;
    int m_y;
    bit m_act;
    bit m_shot;
    bit m_hit;

    always #5 clk = ~clk;

    player_shot_controller #(
        .PLAYER_WIDTH   (PW),
        .MISSILE_WIDTH  (MW),
        .SPAWN_Y        (SPAWN),
        .MISSILE_SPEED  (SPEED),
        .TOP_LIMIT      (TOP),
        .COOLDOWN_FRAMES(COOL)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (sof),
        .firePress      (fire),
        .collision      (col),
        .playerTopLeftX (px),
        .missileTopLeftX(missileTopLeftX),
        .missileTopLeftY(missileTopLeftY),
        .missileActive  (missileActive),
        .shotFired      (shotFired),
        .hitPulse       (hitPulse)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fly = 0; m_cd = 0; m_fprev = 0;
        m_x = 0; m_y = 0; m_act = 0; m_shot = 0; m_hit = 0;
    endtask

    task automatic model_end_flight();
        m_fly = 0;
        m_act = 0;
`ifdef SHOT_COOLDOWN_EN
        m_cd  = COOL;
`endif
    endtask

    task automatic model_clock();
        bit fe;
        if (!resetN) begin
            model_reset();
            return;
        end
        m_shot = 0;
        m_hit  = 0;
        fe = sof && fire && !m_fprev;
        if (m_fly) begin
            if (col) begin
                m_hit = 1;
                model_end_flight();
            end else if (sof) begin
                if (m_y - SPEED >= TOP) m_y = m_y - SPEED;
                else model_end_flight();
            end
        end else if (m_cd > 0) begin
            if (sof) m_cd--;
        end else if (fe) begin
            m_fly  = 1;
            m_act  = 1;
            m_shot = 1;
            m_x    = int'(px) + PW / 2 - MW / 2;
            m_y    = SPAWN;
        end
        if (sof) m_fprev = fire;
    endtask

    task automatic compare_all();
        check("active", missileActive, m_act);
        check("shot", shotFired, m_shot);
        check("hit", hitPulse, m_hit);
        check("x", missileTopLeftX, m_x);
        check("y", missileTopLeftY, m_y);
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        if (shotFired === 1'b1) nShot++;
        compare_all();
    endtask

    task automatic frame(input bit f, input int gap);
        fire = f;
        sof  = 1'b1;
        tick();
        sof  = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        resetN = 1'b0; sof = 1'b0; fire = 1'b0; col = 1'b0; px = '0;
        model_reset();
        #3;
        check("rst_active", missileActive, 0);
        check("rst_shot", shotFired, 0);
        check("rst_hit", hitPulse, 0);
        check("rst_x", missileTopLeftX, 0);
        check("rst_y", missileTopLeftY, 0);
        repeat (2) tick();
        resetN = 1'b1;
        repeat (3) tick();

        // Launch from X=320
        px = 11'sd320; fire = 1'b1; sof = 1'b1;
        tick();
        check("launch_shot", shotFired, 1);
        check("launch_active", missileActive, 1);
        check("launch_x", missileTopLeftX, 350);
        check("launch_y", missileTopLeftY, 290);
        sof = 1'b0;
        tick();
        check("launch_shot_once", shotFired, 0);
        tick();

        // Flight to the top; player moves, missile X stays put
        px = 11'sd100;
        for (int i = 0; i < 36; i++) frame(1'b0, 2);
        check("top_y", missileTopLeftY, 2);
        check("top_active", missileActive, 1);
        check("frozen_x", missileTopLeftX, 350);
        fire = 1'b0; sof = 1'b1;
        tick();
        check("exit_active", missileActive, 0);
        check("exit_hit", hitPulse, 0);
        check("exit_y_hold", missileTopLeftY, 2);
        sof = 1'b0;
        tick();

`ifdef SHOT_COOLDOWN_EN
        // Fire edges during cooldown, including one on the expiring frame
        nShot = 0;
        for (int i = 0; i < COOL; i++) frame((i % 2) == 0, 2);
        check("cooldown_no_shot", nShot, 0);
        frame(1'b0, 2);
        frame(1'b1, 0);
        check("after_cooldown_shot", shotFired, 1);
        repeat (2) tick();
`else
        fire = 1'b1; sof = 1'b1;
        tick();
        check("relaunch_shot", shotFired, 1);
        check("relaunch_x", missileTopLeftX, 130);
        sof = 1'b0;
        repeat (2) tick();
`endif

        // Collision together with SOF at Y=250
        for (int i = 0; i < 5; i++) frame(1'b0, 2);
        check("pre_col_y", missileTopLeftY, 250);
        col = 1'b1; sof = 1'b1;
        tick();
        check("col_hit", hitPulse, 1);
        check("col_y", missileTopLeftY, 250);
        check("col_active", missileActive, 0);
        col = 1'b0; sof = 1'b0;
        tick();
        check("col_hit_once", hitPulse, 0);
        col = 1'b1;
        tick();
        col = 1'b0;
        for (int i = 0; i < 20; i++) frame(1'b0, 1);

        // Hold fire for 100 frames
        nShot = 0;
        for (int i = 0; i < 100; i++) frame(1'b1, 2);
        check("hold_one_shot", nShot, 1);
        for (int i = 0; i < 20; i++) frame(1'b0, 1);

        // Reset mid-flight
        frame(1'b1, 2);
        for (int i = 0; i < 3; i++) frame(1'b0, 2);
        check("pre_rst_active", missileActive, 1);
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check("midrst_active", missileActive, 0);
        check("midrst_shot", shotFired, 0);
        check("midrst_hit", hitPulse, 0);
        check("midrst_x", missileTopLeftX, 0);
        check("midrst_y", missileTopLeftY, 0);
        tick();
        resetN = 1'b1;
        tick();
        check("post_rst_hit", hitPulse, 0);
        frame(1'b1, 0);
        check("post_rst_launch", shotFired, 1);
        fire = 1'b0;
        tick();

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            sof = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) fire = ~fire;
            col = ($urandom_range(0, 40) == 0);
            px  = 11'($urandom_range(0, 600));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
